// File: rtl/serial_add32.sv
// Byte-serial modular adder; the cout port exists only when SERIAL_ADD_COUT_EN is defined.
// Latency NBYTES cycles from acceptance to out_valid; holds result in DONE until out_ready.

module adder8 (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);
    logic [8:0] carry_chain;

    always_comb begin
        s              = '0;
        carry_chain    = '0;
        carry_chain[0] = ci;
        for (int i = 0; i < 8; i++) begin
            s[i]             = x[i] ^ y[i] ^ carry_chain[i];
            carry_chain[i+1] = (x[i] & y[i]) | (carry_chain[i] & (x[i] ^ y[i]));
        end
        co = carry_chain[8];
    end
endmodule

module serial_add32 #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef SERIAL_ADD_COUT_EN
    output logic                  cout,
`endif
    output logic [8*NBYTES-1:0]   sum
);
    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    op_a_q, op_a_d;
    logic [W-1:0]    op_b_q, op_b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            c_q, c_d;
`ifdef SERIAL_ADD_COUT_EN
    logic            cout_q, cout_d;
`endif

    logic [7:0]      add_x, add_y, add_s;
    logic            add_co;
    logic [IDXW+2:0] byte_lsb;

    // Byte offset of the current slice: idx * 8.
    assign byte_lsb = {idx_q, 3'b000};
    assign add_x    = op_a_q[byte_lsb +: 8];
    assign add_y    = op_b_q[byte_lsb +: 8];

    adder8 u_adder8 (
        .x  (add_x),
        .y  (add_y),
        .ci (c_q),
        .s  (add_s),
        .co (add_co)
    );

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        c_d     = c_q;
`ifdef SERIAL_ADD_COUT_EN
        cout_d  = cout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_a_d  = a;
                    op_b_d  = b;
                    idx_d   = '0;
                    c_d     = 1'b0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                sum_d[byte_lsb +: 8] = add_s;
                c_d                  = add_co;
                if (idx_q == LAST_IDX) begin
`ifdef SERIAL_ADD_COUT_EN
                    cout_d  = add_co;
`endif
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            c_q     <= 1'b0;
`ifdef SERIAL_ADD_COUT_EN
            cout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
`ifdef SERIAL_ADD_COUT_EN
            cout_q  <= cout_d;
`endif
        end
    end

    // Handshake flags come straight from the state register.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
`ifdef SERIAL_ADD_COUT_EN
    assign cout      = cout_q;
`endif

endmodule

// File: tb/tb_serial_add32.sv
// Randomized self-checking bench for serial_add32 against a plain-arithmetic sum model.
module tb_serial_add32;
    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
`ifdef SERIAL_ADD_COUT_EN
    logic         cout;
`endif

    int n_err = 0;
    int n_chk = 0;

    serial_add32 #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SERIAL_ADD_COUT_EN
        .cout      (cout),
`endif
        .sum       (sum)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: full-precision sum, split into modular result and carry out.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    // Issue one operation from IDLE, hold DONE for 'stall' cycles while disturbing inputs.
    task automatic run_op(input logic [W-1:0] opa, input logic [W-1:0] opb,
                          input int stall, input bit chk_carry, input string tag);
        logic [W:0] full;
        int lat;
        full = ref_add(opa, opb);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        a         = opa;
        b         = opb;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            if (chk_carry && lat <= NB)
                check({tag, "_carry"}, 64'(dut.c_q), 64'd1);
        end
        check({tag, "_latency"}, 64'(lat), 64'(NB));
        check({tag, "_sum"}, 64'(sum), 64'(full[W-1:0]));
`ifdef SERIAL_ADD_COUT_EN
        check({tag, "_cout"}, 64'(cout), 64'(full[W]));
`endif
        for (int i = 0; i < stall; i++) begin
            in_valid = ~in_valid;
            a        = $urandom;
            b        = $urandom;
            @(negedge clk);
            check({tag, "_hold_sum"}, 64'(sum), 64'(full[W-1:0]));
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_post_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [W:0]   full;
        logic [W-1:0] ra, rb;
        logic [W-1:0] b2b_sum [2];
        int           b2b_cyc [2];
        int           npulse;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_sum", 64'(sum), 64'd0);
`ifdef SERIAL_ADD_COUT_EN
        check("reset_cout", 64'(cout), 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        run_op(32'h12345678, 32'h11111111, 0, 1'b0, "basic");
        run_op(32'h6A09E667, 32'hBB67AE85, 5, 1'b0, "carries");
        run_op(32'hFFFFFFFF, 32'h00000001, 1, 1'b1, "ripple");

        // Abandon an operation after two ADD cycles.
        in_valid = 1'b1;
        a        = 32'hFFFFFFFF;
        b        = 32'h00000001;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_sum", 64'(sum), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
`ifdef SERIAL_ADD_COUT_EN
        check("midrst_cout", 64'(cout), 64'd0);
`endif
        run_op(32'h00000001, 32'h00000001, 0, 1'b0, "after_rst");

        // Back-to-back with out_ready tied high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 32'hDEADBEEF;
        b         = 32'h01020304;
        @(posedge clk);
        @(negedge clk);
        a      = 32'h80000000;
        b      = 32'h80000001;
        npulse = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (npulse == 1 && !in_ready && !out_valid)
                in_valid = 1'b0;
            if (out_valid && npulse < 2) begin
                b2b_sum[npulse] = sum;
                b2b_cyc[npulse] = cyc;
                npulse++;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_pulses", 64'(npulse), 64'd2);
        full = ref_add(32'hDEADBEEF, 32'h01020304);
        check("b2b_sum0", 64'(b2b_sum[0]), 64'(full[W-1:0]));
        full = ref_add(32'h80000000, 32'h80000001);
        check("b2b_sum1", 64'(b2b_sum[1]), 64'(full[W-1:0]));
        check("b2b_spacing", 64'(b2b_cyc[1] - b2b_cyc[0]), 64'(NB + 2));

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 0) rb = ~ra;
            run_op(ra, rb, $urandom_range(0, 3), 1'b0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
